// File: rtl/i2c_slave_responder_if.sv
// I2C-side signal bundle for the responder: the bus lines (scl, sampled sda,
// open-drain enable) plus the register-file side-band outputs.
`timescale 1ns/1ps
interface i2c_slave_responder_if #(
  parameter int PTR_W = 4
);
  logic             scl;
  logic             sda_in;
  logic             sda_oe;
  logic             busy;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             rd_strobe;
  logic [7:0]       nack_cnt;

  // The responder samples the bus and drives the open-drain enable.
  modport slave (
    input  scl, sda_in,
    output sda_oe, busy, wr_strobe, wr_addr, wr_data, rd_strobe, nack_cnt
  );

  // The initiator (bridge or bench) drives the bus and observes the responder.
  modport master (
    output scl, sda_in,
    input  sda_oe, busy, wr_strobe, wr_addr, wr_data, rd_strobe, nack_cnt
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: oversamples scl/sda in the pclk domain, decodes START/STOP,
// ACKs its 7-bit address, writes bytes into a small register file through an
// auto-incrementing pointer and serves reads from the same pointer.
`timescale 1ns/1ps
module i2c_slave_responder #(
  parameter logic [6:0] SLV_ADDR    = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   pclk,
  input  logic                   preset,
  i2c_slave_responder_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_HDR_ACK,
    S_WPTR,
    S_WPTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK,
    S_WAIT_STOP
  } state_t;

  // Synchronizers and edge history
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_s_scl;
  logic                   w_s_sda;
  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic                   w_start;
  logic                   w_stop;

  // Protocol state
  state_t           r_state,     state_nxt;
  logic [3:0]       r_bit_cnt,   bit_cnt_nxt;
  logic [7:0]       r_shift,     shift_nxt;
  logic [PTR_W-1:0] r_ptr,       ptr_nxt;
  logic             r_rw,        rw_nxt;
  logic             r_sda_oe,    sda_oe_nxt;
  logic             r_busy,      busy_nxt;
  logic             r_wr_strobe, wr_strobe_nxt;
  logic [PTR_W-1:0] r_wr_addr,   wr_addr_nxt;
  logic [7:0]       r_wr_data,   wr_data_nxt;
  logic             r_rd_strobe, rd_strobe_nxt;
  logic [7:0]       r_nack_cnt,  nack_cnt_nxt;

  logic [7:0]       r_regs [NUM_REGS];

  logic             w_rx_state;
  logic             w_rx_last;
  logic [7:0]       w_rx_byte;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [7:0]       w_rd_byte;
  logic [7:0]       w_rd_next;

  // Bring scl/sda into the pclk domain; idle-high reset so no false edge appears.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_d    <= w_s_scl;
      r_sda_d    <= w_s_sda;
    end
  end

  assign w_s_scl    = r_scl_sync[SYNC_STAGES-1];
  assign w_s_sda    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_s_scl & ~r_scl_d;
  assign w_scl_fall = ~w_s_scl &  r_scl_d;
  assign w_start    = ~w_s_sda &  r_sda_d & w_s_scl;
  assign w_stop     =  w_s_sda & ~r_sda_d & w_s_scl;

  assign w_rx_state = (r_state == S_HDR) || (r_state == S_WPTR) || (r_state == S_WDATA);
  assign w_rx_last  = w_rx_state && w_scl_rise && (r_bit_cnt == 4'd7);
  assign w_rx_byte  = {r_shift[6:0], w_s_sda};
  assign w_ptr_inc  = r_ptr + PTR_W'(1);
  assign w_rd_byte  = r_regs[r_ptr];
  assign w_rd_next  = r_regs[w_ptr_inc];

  // State and output registers; sda_oe clears asynchronously so reset frees the bus at once.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_strobe <= 1'b0;
      r_nack_cnt  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state     <= state_nxt;
      r_bit_cnt   <= bit_cnt_nxt;
      r_shift     <= shift_nxt;
      r_ptr       <= ptr_nxt;
      r_rw        <= rw_nxt;
      r_sda_oe    <= sda_oe_nxt;
      r_busy      <= busy_nxt;
      r_wr_strobe <= wr_strobe_nxt;
      r_wr_addr   <= wr_addr_nxt;
      r_wr_data   <= wr_data_nxt;
      r_rd_strobe <= rd_strobe_nxt;
      r_nack_cnt  <= nack_cnt_nxt;
    end
  end

  // Next-state logic: START/STOP first, then bit-level sample (scl rise) and drive (scl fall) events.
  always_comb begin
    // NOTE: every target gets a hold/default value first, so no path can infer a latch.
    state_nxt     = r_state;
    bit_cnt_nxt   = r_bit_cnt;
    shift_nxt     = r_shift;
    ptr_nxt       = r_ptr;
    rw_nxt        = r_rw;
    sda_oe_nxt    = r_sda_oe;
    busy_nxt      = r_busy;
    wr_strobe_nxt = 1'b0;
    wr_addr_nxt   = r_wr_addr;
    wr_data_nxt   = r_wr_data;
    rd_strobe_nxt = 1'b0;
    nack_cnt_nxt  = r_nack_cnt;

    if (w_start) begin
      state_nxt   = S_HDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else if (w_stop) begin
      state_nxt   = S_IDLE;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      // Receiving states shift MSB first on every sample event.
      if (w_rx_state && w_scl_rise) begin
        shift_nxt   = w_rx_byte;
        bit_cnt_nxt = r_bit_cnt + 4'd1;
      end

      case (r_state)
        S_IDLE: begin
          sda_oe_nxt = 1'b0;
          busy_nxt   = 1'b0;
        end

        S_HDR: begin
          if (w_rx_last) begin
            bit_cnt_nxt = '0;
            if (w_rx_byte[7:1] == SLV_ADDR) begin
              state_nxt = S_HDR_ACK;
              busy_nxt  = 1'b1;
              rw_nxt    = w_rx_byte[0];
            end else begin
              state_nxt = S_WAIT_STOP;
            end
          end
        end

        S_HDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else if (r_rw) begin
              // ACK ends on the same fall that must present the first read bit.
              state_nxt     = S_RDATA;
              rd_strobe_nxt = 1'b1;
              sda_oe_nxt    = ~w_rd_byte[7];
              shift_nxt     = {w_rd_byte[6:0], 1'b0};
              bit_cnt_nxt   = 4'd1;
            end else begin
              state_nxt   = S_WPTR;
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
            end
          end
        end

        S_WPTR: begin
          if (w_rx_last) begin
            bit_cnt_nxt = '0;
            ptr_nxt     = w_rx_byte[PTR_W-1:0];
            state_nxt   = S_WPTR_ACK;
          end
        end

        S_WDATA: begin
          if (w_rx_last) begin
            bit_cnt_nxt   = '0;
            wr_strobe_nxt = 1'b1;
            wr_addr_nxt   = r_ptr;
            wr_data_nxt   = w_rx_byte;
            ptr_nxt       = w_ptr_inc;
            state_nxt     = S_WDATA_ACK;
          end
        end

        S_WPTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              state_nxt   = S_WDATA;
              bit_cnt_nxt = '0;
            end
          end
        end

        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              state_nxt   = S_RACK;
              bit_cnt_nxt = '0;
            end else begin
              sda_oe_nxt  = ~r_shift[7];
              shift_nxt   = {r_shift[6:0], 1'b0};
              bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end

        S_RACK: begin
          if (w_scl_rise) begin
            if (!w_s_sda) begin
              ptr_nxt       = w_ptr_inc;
              shift_nxt     = w_rd_next;
              rd_strobe_nxt = 1'b1;
              bit_cnt_nxt   = '0;
              state_nxt     = S_RDATA;
            end else begin
              if (r_nack_cnt != 8'hFF) begin
                nack_cnt_nxt = r_nack_cnt + 8'd1;
              end
              state_nxt = S_WAIT_STOP;
            end
          end
        end

        S_WAIT_STOP: begin
          sda_oe_nxt = 1'b0;
        end

        default: begin
          state_nxt  = S_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // Register file: one byte written per completed write-data byte.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      // NOTE: this memory is reset because its cleared contents are readable over the bus after reset.
      r_regs <= '{default: 8'h00};
    end else if (wr_strobe_nxt) begin
      r_regs[r_ptr] <= w_rx_byte;
    end
  end

  assign bus.sda_oe    = r_sda_oe;
  assign bus.busy      = r_busy;
  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.rd_strobe = r_rd_strobe;
  assign bus.nack_cnt  = r_nack_cnt;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-level I2C initiator drives the bus,
// a register-file model predicts writes and read bytes, and a monitor process
// pops the expected queues whenever the DUT presents a write strobe or a read byte.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam int Q        = 6;   // pclk cycles per quarter scl period
  localparam int PTR_W    = 4;
  localparam int NUM_REGS = 16;

  logic pclk = 1'b0;
  logic preset;
  logic m_sda;

  always #5 pclk = ~pclk;

  i2c_slave_responder_if #(.PTR_W(PTR_W)) bus();

  // Wired-AND open-drain line: either side may pull low.
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_slave_responder #(
    .SLV_ADDR   (7'h50),
    .NUM_REGS   (NUM_REGS),
    .PTR_W      (PTR_W),
    .SYNC_STAGES(2)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  typedef struct {
    logic [PTR_W-1:0] addr;
    logic [7:0]       data;
  } wr_exp_t;

  wr_exp_t    exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] obs_rd_q[$];
  logic [7:0] tx_q[$];

  logic [7:0] model_regs [NUM_REGS];
  int         model_ptr;
  int         model_nack;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    model_ptr  = 0;
    model_nack = 0;
  endtask

  // ---------------- bit-level initiator ----------------
  task automatic i2c_start();
    wait_q(Q); m_sda = 1'b1;
    wait_q(Q); bus.scl = 1'b1;
    wait_q(Q); m_sda = 1'b0;
    wait_q(Q); bus.scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(Q); m_sda = 1'b0;
    wait_q(Q); bus.scl = 1'b1;
    wait_q(Q); m_sda = 1'b1;
    wait_q(Q);
  endtask

  task automatic xfer_bit(input logic drive, output logic smp, output logic oe);
    wait_q(Q); m_sda = drive;
    wait_q(Q); bus.scl = 1'b1;
    wait_q(Q); smp = bus.sda_in; oe = bus.sda_oe;
    wait_q(Q); bus.scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s, oe;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], s, oe);
    xfer_bit(1'b1, s, oe);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack_it);
    logic [7:0] got;
    logic s, oe;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s, oe);
      got[i] = s;
    end
    xfer_bit(~ack_it, s, oe);
    check("sda_released_in_master_ack", 32'(oe), 32'd0);
    obs_rd_q.push_back(got);
  endtask

  // ---------------- transactions with model update ----------------
  task automatic wr_txn(input logic [7:0] ptr);
    logic    ack;
    wr_exp_t e;
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_hdr_ack", 32'(ack), 32'd1);
    check("busy_after_match", 32'(bus.busy), 32'd1);
    write_byte(ptr, ack);
    check("wr_ptr_ack", 32'(ack), 32'd1);
    model_ptr = ptr % NUM_REGS;
    foreach (tx_q[i]) begin
      e.addr = PTR_W'(model_ptr);
      e.data = tx_q[i];
      exp_wr_q.push_back(e);
      model_regs[model_ptr] = tx_q[i];
      model_ptr = (model_ptr + 1) % NUM_REGS;
      write_byte(tx_q[i], ack);
      check("wr_data_ack", 32'(ack), 32'd1);
    end
    i2c_stop();
    wait_q(8);
    check("busy_after_stop", 32'(bus.busy), 32'd0);
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] ptr, input int n);
    logic ack;
    int   rd0;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hA0, ack);
      check("rd_setptr_hdr_ack", 32'(ack), 32'd1);
      write_byte(ptr, ack);
      check("rd_setptr_ptr_ack", 32'(ack), 32'd1);
      model_ptr = ptr % NUM_REGS;
      i2c_start();
    end
    rd0 = rd_cnt;
    write_byte(8'hA1, ack);
    check("rd_hdr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(model_regs[model_ptr]);
      read_byte(i != n - 1);
      if (i != n - 1) model_ptr = (model_ptr + 1) % NUM_REGS;
    end
    if (model_nack < 255) model_nack++;
    i2c_stop();
    wait_q(8);
    check("rd_strobe_count", 32'(rd_cnt - rd0), 32'(n));
    check("nack_cnt", 32'(bus.nack_cnt), 32'(model_nack));
    check("busy_after_rd_stop", 32'(bus.busy), 32'd0);
  endtask

  task automatic bad_addr_txn(input logic [7:0] hdr);
    logic ack;
    i2c_start();
    write_byte(hdr, ack);
    check("bad_hdr_nack", 32'(ack), 32'd0);
    check("bad_hdr_busy", 32'(bus.busy), 32'd0);
    write_byte(8'h55, ack);
    check("bad_hdr_data_ignored", 32'(ack), 32'd0);
    i2c_stop();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    wr_exp_t    e;
    logic [7:0] a, x;
    forever begin
      @(negedge pclk);
      if (bus.rd_strobe === 1'b1) rd_cnt++;
      if (bus.wr_strobe === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_strobe_unexpected", 32'(bus.wr_strobe), 32'd0);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
      end
      while (obs_rd_q.size() > 0) begin
        a = obs_rd_q.pop_front();
        if (exp_rd_q.size() == 0) begin
          check("rd_byte_unexpected", 32'(obs_rd_q.size() + 1), 32'd0);
        end else begin
          x = exp_rd_q.pop_front();
          check("rd_byte", 32'(a), 32'(x));
        end
      end
    end
  end

  // Watchdog: the stimulus is purely time-driven, this only guards against a stuck run.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic ack;
    logic s, oe;
    int   kind;
    logic [6:0] addr;

    preset  = 1'b0;
    bus.scl = 1'b1;
    m_sda   = 1'b1;
    model_reset();
    wait_q(5);
    check("rst_sda_oe",    32'(bus.sda_oe),    32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_wr_strobe", 32'(bus.wr_strobe), 32'd0);
    check("rst_rd_strobe", 32'(bus.rd_strobe), 32'd0);
    check("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    check("rst_wr_data",   32'(bus.wr_data),   32'd0);
    check("rst_nack_cnt",  32'(bus.nack_cnt),  32'd0);
    preset = 1'b1;
    wait_q(10);

    // Basic write: ptr 3, data 5A C3
    tx_q = '{8'h5A, 8'hC3};
    wr_txn(8'h03);

    // Wrong address: never ACKed, no effect
    bad_addr_txn(8'hA4);

    // Pointer wrap: reg[15]=11, reg[0]=22
    tx_q = '{8'h11, 8'h22};
    wr_txn(8'h0F);

    // Set ptr 0F, repeated START, read two bytes (ACK then NACK)
    rd_txn(1'b1, 8'h0F, 2);

    // STOP after 4 data bits: nothing written, pointer stays at 5
    tx_q = '{8'hA7};
    wr_txn(8'h05);
    i2c_start();
    write_byte(8'hA0, ack);
    check("partial_hdr_ack", 32'(ack), 32'd1);
    write_byte(8'h05, ack);
    check("partial_ptr_ack", 32'(ack), 32'd1);
    model_ptr = 5;
    for (int i = 0; i < 4; i++) xfer_bit(i[0], s, oe);
    i2c_stop();
    wait_q(8);
    check("partial_busy", 32'(bus.busy), 32'd0);
    rd_txn(1'b0, 8'h00, 1);

    // Reset in the middle of a read byte while the responder pulls sda low
    tx_q = '{8'h3C};
    wr_txn(8'h00);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rst_rd_hdr_ack", 32'(ack), 32'd1);
    wait_q(Q);
    check("sda_oe_before_reset", 32'(bus.sda_oe), 32'd1);
    preset = 1'b0;
    #1;
    check("sda_oe_async_reset", 32'(bus.sda_oe), 32'd0);
    check("busy_async_reset",   32'(bus.busy),   32'd0);
    bus.scl = 1'b1;
    m_sda   = 1'b1;
    model_reset();
    wait_q(4);
    preset = 1'b1;
    wait_q(10);
    rd_txn(1'b0, 8'h00, 2);

    // Randomised traffic against the model
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        tx_q.delete();
        for (int i = 0; i < $urandom_range(1, 4); i++) tx_q.push_back(8'($urandom()));
        wr_txn(8'($urandom()));
      end else if (kind == 2) begin
        rd_txn(1'($urandom()), 8'($urandom()), $urandom_range(1, 4));
      end else begin
        addr = 7'($urandom());
        if (addr == 7'h50) addr = 7'h51;
        bad_addr_txn({addr, 1'($urandom())});
      end
    end

    wait_q(20);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
